bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised synchronous BCD modulo-N counter for the multi-function digital clock. It is the general replacement for the fixed mod-60 seconds/minutes counter and also covers the hour counter: 24-hour 00..23 and 12-hour 01..12. Counters cascade through `co` into the next stage's `en`. A minute/hour adjust step is built in, together with a range-checked parallel BCD load for time setting and optional down-counting for countdown and alarm modes.

## Interface
Parameters:
- `DIGITS`, 2: number of BCD digits; legal range 1..4.
- `MOD`, 60: count modulus; MOD ≥ 2.
- `BASE`, 0: lowest count value, e.g. 1 for 12-hour mode. Elaboration fails unless BASE+MOD ≤ 10^DIGITS.

Ports:
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  count enable, normally the lower stage's `co`.
- `adj`  in  1  adjust step; counts one step, never produces carry/borrow.
- `ld`  in  1  parallel load strobe.
- `din`  in  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- `dir`  in  1  1 = up, 0 = down (honoured only with the macro).
- `dout`  out  4*DIGITS  current value, packed BCD, registered.
- `co`  out  1  carry, combinational.
- `bo`  out  1  borrow, combinational.
- `err`  out  1  load-rejected flag, registered.

## Operation
- Value range: BASE..TOP, where TOP = BASE+MOD-1. `dout` is always legal BCD and always in range.
- Per-edge priority: `rst_n`=0 > `ld` > `adj` > `en`. At most one action per cycle.
- Reset:
  - `dout` ← BCD(BASE).
  - `err` ← 0.
- Load (`ld`=1):
  - Accepted when every digit of `din` is ≤ 9 and BASE ≤ value ≤ TOP. Then `dout` ← `din` and `err` ← 0.
  - Otherwise `dout` is unchanged and `err` ← 1.
  - `err` holds until the next accepted load or reset.
- Step (`adj`=1, or `en`=1 with `ld`=`adj`=0):
  - Up: TOP → BASE. Otherwise increment digit 0; any digit reaching 10 rolls to 0 and carries into the next digit.
  - Down: BASE → TOP. Otherwise decrement with per-digit 0 → 9 borrow.
- Carry and borrow:
  - `co` = `en` & ~`ld` & ~`adj` & up & (`dout`==TOP).
  - `bo` = `en` & ~`ld` & ~`adj` & down & (`dout`==BASE).
  - Adjust steps therefore never propagate to the next stage.
- `en` low with no `ld`/`adj`: `dout` holds.

## Timing
- `dout` and `err` change only on a rising edge of `clk`, one cycle after the qualifying input.
- `co` and `bo` are combinational in the same cycle as `en`. The next stage samples them at the edge on which this stage wraps, which gives zero-latency cascade.
- Reset mid-operation takes effect at the next edge regardless of `ld`/`adj`/`en`. `co`/`bo` are forced 0 while `rst_n`=0.
- No combinational path from `din` to any output.

## Configuration
- `BCD_COUNTER_DOWN_EN` defined:
  - `dir` selects the count direction.
  - `bo` is active.
- Not defined:
  - The counter is up-only and `dir` is ignored.
  - `bo` is tied 0.
  - Down-count logic is not synthesised.

## Test plan
- Reset and wrap: DIGITS=2, MOD=60, BASE=0; hold `en`=1 from reset. `dout` runs 0x00..0x59 and then 0x00. `co`=1 only during the 0x59 cycle. 0x09→0x10 shows the digit carry.
- 12-hour config: MOD=12, BASE=1. Reset gives `dout`=0x01; wrap is 0x12→0x01 with `co`=1. Load `din`=0x00 leaves `dout` unchanged with `err`=1. A following load of 0x07 gives `dout`=0x07 with `err`=0.
- Priority: at `dout`=0x59, drive `adj`=`en`=1 → `dout`=0x00, `co`=0. Drive `ld`=`adj`=`en`=1 with `din`=0x30 → `dout`=0x30.
- Illegal BCD load: `din`=0x3A → rejected, `err`=1, `dout` held.
- Down mode (macro defined): MOD=24, `dir`=0, start at 0x00, `en`=1. `bo`=1 in that cycle, then `dout`=0x23, 0x22, …; 0x10→0x09 shows the digit borrow.
- Cascade: two instances, seconds `co` → minutes `en`. From 00:59 with `en`=1, the next edge gives minutes 0x01 and seconds 0x00. Reset asserted during counting gives both 0x00 at the next edge.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Cascadable BCD modulo-MOD counter (BASE..BASE+MOD-1) with load, adjust and carry/borrow; dout/err one cycle, co/bo same cycle.
// No backpressure: one action per edge (reset > ld > adj > en); BCD_COUNTER_DOWN_EN enables dir-controlled down-counting and bo.
module bcd_mod_counter #(
  parameter int DIGITS = 2,
  parameter int MOD    = 60,
  parameter int BASE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  adj,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  co,
  output logic                  bo,
  output logic                  err
);

  localparam int W   = 4 * DIGITS;
  localparam int TOP = BASE + MOD - 1;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] BASE_BCD = to_bcd(BASE);
  localparam logic [W-1:0] TOP_BCD  = to_bcd(TOP);

  generate
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $error("bcd_mod_counter: DIGITS must be 1..4");
    end
    if (MOD < 2) begin : g_bad_mod
      $error("bcd_mod_counter: MOD must be >= 2");
    end
    if (BASE < 0 || BASE + MOD > pow10(DIGITS)) begin : g_bad_range
      $error("bcd_mod_counter: BASE+MOD exceeds the BCD digit range");
    end
  endgenerate

  // Ripple increment: a digit at 9 rolls to 0 and passes the carry upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef BCD_COUNTER_DOWN_EN
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction
`endif

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         up;
  logic         at_top;
  logic         din_digits_ok;
  logic         din_lo_ok;
  logic         din_hi_ok;
  logic         din_ok;
  logic         cnt_step;

`ifdef BCD_COUNTER_DOWN_EN
  logic         at_base;
  assign up      = dir;
  assign at_base = (cnt_q == BASE_BCD);
`else
  logic         unused_dir;
  assign up         = 1'b1;
  assign unused_dir = dir;
`endif

  assign at_top   = (cnt_q == TOP_BCD);
  assign cnt_step = en & ~ld & ~adj;

  always_comb begin
    din_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (din[4*i +: 4] > 4'd9) din_digits_ok = 1'b0;
    end
  end

  // Packed BCD orders like the number it encodes once every digit is legal.
  generate
    if (BASE == 0) begin : g_lo_zero
      assign din_lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign din_lo_ok = (din >= BASE_BCD);
    end
  endgenerate

  assign din_hi_ok = (din <= TOP_BCD);
  assign din_ok    = din_digits_ok & din_lo_ok & din_hi_ok;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (ld) begin
      if (din_ok) begin
        cnt_d = din;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (adj || en) begin
      if (up) begin
        cnt_d = at_top ? BASE_BCD : bcd_inc(cnt_q);
      end else begin
`ifdef BCD_COUNTER_DOWN_EN
        cnt_d = at_base ? TOP_BCD : bcd_dec(cnt_q);
`else
        cnt_d = cnt_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= BASE_BCD;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign dout = cnt_q;
  assign err  = err_q;
  assign co   = rst_n & cnt_step & up & at_top;

`ifdef BCD_COUNTER_DOWN_EN
  assign bo   = rst_n & cnt_step & ~up & at_base;
`else
  assign bo   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: mod-60 seconds cascaded into minutes, 12-hour (BASE=1) and 24-hour counters.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_bcd_mod_counter;

  logic       clk;
  logic       rst_n;

  logic       s_en, s_adj, s_ld, s_dir;
  logic [7:0] s_din, s_dout;
  logic       s_co, s_bo, s_err;

  logic       m_ld;
  logic [7:0] m_din, m_dout;
  logic       m_co, m_bo, m_err;

  logic       h_en, h_adj, h_ld, h_dir;
  logic [7:0] h_din, h_dout;
  logic       h_co, h_bo, h_err;

  logic       d_en, d_adj, d_ld, d_dir;
  logic [7:0] d_din, d_dout;
  logic       d_co, d_bo, d_err;

  int n_vec;
  int n_err;

  bcd_mod_counter #(.DIGITS(2), .MOD(60), .BASE(0)) u_sec (
    .clk(clk), .rst_n(rst_n), .en(s_en), .adj(s_adj), .ld(s_ld), .din(s_din),
    .dir(s_dir), .dout(s_dout), .co(s_co), .bo(s_bo), .err(s_err));

  bcd_mod_counter #(.DIGITS(2), .MOD(60), .BASE(0)) u_min (
    .clk(clk), .rst_n(rst_n), .en(s_co), .adj(1'b0), .ld(m_ld), .din(m_din),
    .dir(1'b1), .dout(m_dout), .co(m_co), .bo(m_bo), .err(m_err));

  bcd_mod_counter #(.DIGITS(2), .MOD(12), .BASE(1)) u_h12 (
    .clk(clk), .rst_n(rst_n), .en(h_en), .adj(h_adj), .ld(h_ld), .din(h_din),
    .dir(h_dir), .dout(h_dout), .co(h_co), .bo(h_bo), .err(h_err));

  bcd_mod_counter #(.DIGITS(2), .MOD(24), .BASE(0)) u_h24 (
    .clk(clk), .rst_n(rst_n), .en(d_en), .adj(d_adj), .ld(d_ld), .din(d_din),
    .dir(d_dir), .dout(d_dout), .co(d_co), .bo(d_bo), .err(d_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] b2(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    s_en = 0; s_adj = 0; s_ld = 0; s_dir = 1; s_din = 8'h00;
    m_ld = 0; m_din = 8'h00;
    h_en = 0; h_adj = 0; h_ld = 0; h_dir = 1; h_din = 8'h00;
    d_en = 0; d_adj = 0; d_ld = 0; d_dir = 1; d_din = 8'h00;
    repeat (2) tick();

    chk("rst_sec", s_dout, 8'h00);
    chk("rst_sec_err", s_err, 1'b0);
    chk("rst_min", m_dout, 8'h00);
    chk("rst_h12", h_dout, 8'h01);
    chk("rst_h12_err", h_err, 1'b0);
    chk("rst_h24", d_dout, 8'h00);

    // Free-run seconds from reset: 00..59, carry only in the 59 cycle.
    rst_n = 1'b1;
    s_en  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      chk("run60_dout", s_dout, b2(i));
      chk("run60_co", s_co, (i == 59));
      chk("run60_bo", s_bo, 1'b0);
      tick();
    end
    chk("wrap60_sec", s_dout, 8'h00);
    chk("cascade_min", m_dout, 8'h01);
    s_en = 1'b0;
    tick();
    chk("hold_sec", s_dout, 8'h00);

    // Priority: adj beats en and suppresses carry; ld beats both.
    s_ld = 1; s_din = 8'h59;
    tick();
    s_ld = 0;
    chk("load59", s_dout, 8'h59);
    s_adj = 1; s_en = 1;
    #1;
    chk("adj_no_co", s_co, 1'b0);
    tick();
    s_adj = 0; s_en = 0;
    chk("adj_wrap", s_dout, 8'h00);
    chk("adj_min_held", m_dout, 8'h01);
    s_ld = 1; s_adj = 1; s_en = 1; s_din = 8'h30;
    #1;
    chk("ld_prio_co", s_co, 1'b0);
    tick();
    s_ld = 0; s_adj = 0; s_en = 0;
    chk("ld_prio", s_dout, 8'h30);
    chk("ld_prio_err", s_err, 1'b0);

    // Rejected loads: illegal digit and out of range.
    s_ld = 1; s_din = 8'h3A;
    tick();
    chk("bad_bcd_dout", s_dout, 8'h30);
    chk("bad_bcd_err", s_err, 1'b1);
    s_din = 8'h45;
    tick();
    chk("good45_dout", s_dout, 8'h45);
    chk("good45_err", s_err, 1'b0);
    s_din = 8'h60;
    tick();
    s_ld = 0;
    chk("over60_dout", s_dout, 8'h45);
    chk("over60_err", s_err, 1'b1);
    s_adj = 1;
    tick();
    s_adj = 0;
    chk("adj_step", s_dout, 8'h46);
    chk("err_sticky", s_err, 1'b1);

    // 12-hour counter: 01..12 then back to 01.
    h_en = 1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      chk("run12_dout", h_dout, b2(i));
      chk("run12_co", h_co, (i == 12));
      tick();
    end
    h_en = 0;
    chk("wrap12", h_dout, 8'h01);
    h_ld = 1; h_din = 8'h00;
    tick();
    chk("h12_ld00_dout", h_dout, 8'h01);
    chk("h12_ld00_err", h_err, 1'b1);
    h_din = 8'h07;
    tick();
    chk("h12_ld07_dout", h_dout, 8'h07);
    chk("h12_ld07_err", h_err, 1'b0);
    h_din = 8'h13;
    tick();
    chk("h12_ld13_dout", h_dout, 8'h07);
    chk("h12_ld13_err", h_err, 1'b1);
    h_din = 8'h12;
    tick();
    h_ld = 0;
    chk("h12_ld12", h_dout, 8'h12);
    h_adj = 1; h_en = 1;
    #1;
    chk("h12_adj_co", h_co, 1'b0);
    tick();
    h_adj = 0; h_en = 0;
    chk("h12_adj_wrap", h_dout, 8'h01);

    // 24-hour counter with dir=0.
    d_dir = 0;
    d_en  = 1;
`ifdef BCD_COUNTER_DOWN_EN
    for (int k = 0; k <= 24; k++) begin
      #1;
      chk("down24_dout", d_dout, b2((24 - k) % 24));
      chk("down24_bo", d_bo, (k % 24 == 0));
      chk("down24_co", d_co, 1'b0);
      tick();
    end
    chk("down24_wrap", d_dout, 8'h23);
    d_dir = 1;
    #1;
    chk("up24_co", d_co, 1'b1);
    chk("up24_bo", d_bo, 1'b0);
    tick();
    chk("up24_wrap", d_dout, 8'h00);
`else
    for (int k = 0; k <= 24; k++) begin
      #1;
      chk("up24_dout", d_dout, b2(k % 24));
      chk("up24_co", d_co, (k % 24 == 23));
      chk("up24_bo", d_bo, 1'b0);
      tick();
    end
    chk("up24_next", d_dout, 8'h01);
`endif
    d_en = 0;

    // Reset during counting overrides ld/en and forces co low.
    s_ld = 1; s_din = 8'h59; m_ld = 1; m_din = 8'h12;
    tick();
    m_ld = 0;
    s_din = 8'h5A;
    tick();
    s_ld = 0;
    chk("pre_rst_sec", s_dout, 8'h59);
    chk("pre_rst_min", m_dout, 8'h12);
    chk("pre_rst_err", s_err, 1'b1);
    rst_n = 0; s_en = 1; s_ld = 1; s_din = 8'h33;
    #1;
    chk("rst_co_forced", s_co, 1'b0);
    tick();
    rst_n = 1; s_en = 0; s_ld = 0;
    chk("midrst_sec", s_dout, 8'h00);
    chk("midrst_min", m_dout, 8'h00);
    chk("midrst_err", s_err, 1'b0);
    chk("midrst_h12", h_dout, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
